// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared widths, FSM states and weight saturation for neuron_trainer
package neuron_pkg;
    localparam int W_WIDTH   = 14;
    localparam int X_WIDTH   = 7;
    localparam int T_WIDTH   = 2;
    localparam int ACC_WIDTH = 23;

    localparam logic signed [ACC_WIDTH-1:0] W_MAX = ACC_WIDTH'((1 << (W_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] W_MIN = ACC_WIDTH'(-(1 << (W_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, REQ, UPDATE, DONE} state_t;

    function automatic logic signed [W_WIDTH-1:0] sat_w(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] c;
        if (v > W_MAX)
            c = W_MAX;
        else if (v < W_MIN)
            c = W_MIN;
        else
            c = v;
        return c[W_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/neuron_activation.sv
// rtl/neuron_activation.sv - bipolar threshold activation with a symmetric dead zone of THETA
module neuron_activation
    import neuron_pkg::*;
#(
    parameter int THETA = 0
) (
    input  logic signed [ACC_WIDTH-1:0] yin,
    output logic signed [T_WIDTH-1:0]   y
);
    localparam logic signed [ACC_WIDTH-1:0] TH = ACC_WIDTH'(THETA);

    always_comb begin
        y = '0;
        if (yin > TH)
            y = T_WIDTH'(1);
        else if (yin < -TH)
            y = '1;
    end
endmodule

// File: rtl/neuron_trainer.sv
// rtl/neuron_trainer.sv - perceptron trainer for two inputs plus bias, repeating epochs until no change
// Optional epoch limit: define NEURON_EPOCH_LIMIT_EN to stop after MAX_EPOCHS unconverged epochs.
module neuron_trainer
    import neuron_pkg::*;
#(
    parameter int ALPHA      = 1,
    parameter int THETA      = 0,
    parameter int W_WIDTH    = 14,
    parameter int MAX_EPOCHS = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 nInput,
    input  logic signed [X_WIDTH-1:0]   x1Input,
    input  logic signed [X_WIDTH-1:0]   x2Input,
    input  logic signed [T_WIDTH-1:0]   tInput,
    input  logic                        dataReady,
    output logic                        requestFlag,
    output logic                        done,
    output logic signed [W_WIDTH-1:0]   w1,
    output logic signed [W_WIDTH-1:0]   w2,
    output logic signed [W_WIDTH-1:0]   b
);
    localparam logic signed [ACC_WIDTH-1:0] ALPHA_A = ACC_WIDTH'(ALPHA);

    state_t                      state, state_n;
    logic [31:0]                 n_reg, cnt, cnt_inc;
    logic                        changed, changed_n, miss, epoch_end, epoch_limit;
    logic signed [X_WIDTH-1:0]   x1_r, x2_r;
    logic signed [T_WIDTH-1:0]   t_r, y;
    logic signed [ACC_WIDTH-1:0] yin, db, d1, d2;

    assign yin = ACC_WIDTH'(b) + ACC_WIDTH'(w1) * ACC_WIDTH'(x1_r) + ACC_WIDTH'(w2) * ACC_WIDTH'(x2_r);
    assign db  = ALPHA_A * ACC_WIDTH'(t_r);
    assign d1  = db * ACC_WIDTH'(x1_r);
    assign d2  = db * ACC_WIDTH'(x2_r);

    neuron_activation #(.THETA(THETA)) u_act (
        .yin (yin),
        .y   (y)
    );

    // A zero target still counts as a miss when the neuron fires, even though the update is zero.
    assign miss      = (y != t_r);
    assign changed_n = changed | miss;
    assign cnt_inc   = cnt + 32'd1;
    assign epoch_end = (cnt_inc == n_reg);

`ifdef NEURON_EPOCH_LIMIT_EN
    logic [31:0] epochs;

    always_ff @(posedge clk) begin
        if (rst)
            epochs <= '0;
        else if (state == IDLE && start)
            epochs <= '0;
        else if (state == UPDATE && epoch_end)
            epochs <= epochs + 32'd1;
    end

    assign epoch_limit = ((epochs + 32'd1) >= 32'(MAX_EPOCHS));
`else
    logic unused_max_epochs;
    assign unused_max_epochs = (MAX_EPOCHS != 0);
    assign epoch_limit       = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (nInput == 32'd0) ? DONE : REQ;
            REQ:     if (dataReady) state_n = UPDATE;
            UPDATE:  state_n = (epoch_end && (!changed_n || epoch_limit)) ? DONE : REQ;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            requestFlag <= 1'b0;
            done        <= 1'b0;
            w1          <= '0;
            w2          <= '0;
            b           <= '0;
            n_reg       <= '0;
            cnt         <= '0;
            changed     <= 1'b0;
            x1_r        <= '0;
            x2_r        <= '0;
            t_r         <= '0;
        end else begin
            state       <= state_n;
            requestFlag <= (state_n == REQ);
            done        <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg   <= nInput;
                        w1      <= '0;
                        w2      <= '0;
                        b       <= '0;
                        cnt     <= '0;
                        changed <= 1'b0;
                    end
                end
                REQ: begin
                    if (dataReady) begin
                        x1_r <= x1Input;
                        x2_r <= x2Input;
                        t_r  <= tInput;
                    end
                end
                UPDATE: begin
                    if (miss) begin
                        w1 <= sat_w(ACC_WIDTH'(w1) + d1);
                        w2 <= sat_w(ACC_WIDTH'(w2) + d2);
                        b  <= sat_w(ACC_WIDTH'(b) + db);
                    end
                    if (epoch_end) begin
                        cnt     <= '0;
                        changed <= 1'b0;
                    end else begin
                        cnt     <= cnt_inc;
                        changed <= changed_n;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_trainer.sv
// tb/tb_neuron_trainer.sv - randomized self-checking bench for neuron_trainer against an integer perceptron model
module tb_neuron_trainer;
    localparam int ALPHA     = 1;
    localparam int SAT_THETA = 2000000;

    logic              clk = 1'b0;
    logic              rst, start, dataReady;
    logic [31:0]       nInput;
    logic signed [6:0] x1Input, x2Input;
    logic signed [1:0] tInput;
    logic              requestFlag, done;
    logic signed [13:0] w1, w2, b;

    logic              s_start, s_dr, s_req, s_done;
    logic [31:0]       s_n;
    logic signed [6:0] s_x1, s_x2;
    logic signed [1:0] s_t;
    logic signed [13:0] s_w1, s_w2, s_b;

    int errors = 0;
    int checks = 0;
    int sx1[8], sx2[8], st[8];

    always #5 clk = ~clk;

    neuron_trainer #(.ALPHA(ALPHA), .THETA(0), .W_WIDTH(14), .MAX_EPOCHS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .nInput(nInput),
        .x1Input(x1Input), .x2Input(x2Input), .tInput(tInput), .dataReady(dataReady),
        .requestFlag(requestFlag), .done(done), .w1(w1), .w2(w2), .b(b)
    );

    neuron_trainer #(.ALPHA(ALPHA), .THETA(SAT_THETA), .W_WIDTH(14), .MAX_EPOCHS(1024)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .nInput(s_n),
        .x1Input(s_x1), .x2Input(s_x2), .tInput(s_t), .dataReady(s_dr),
        .requestFlag(s_req), .done(s_done), .w1(s_w1), .w2(s_w2), .b(s_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int act(input int yin, input int theta);
        if (yin > theta) return 1;
        if (yin < -theta) return -1;
        return 0;
    endfunction

    function automatic int clamp(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; dataReady = 1'b0; s_start = 1'b0; s_dr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_and();
        sx1 = '{1, 1, -1, -1, 0, 0, 0, 0};
        sx2 = '{1, -1, 1, -1, 0, 0, 0, 0};
        st  = '{1, -1, -1, -1, 0, 0, 0, 0};
    endtask

    task automatic check_weights(input string tag, input int e1, input int e2, input int eb);
        check({tag, "_w1"}, int'(w1), e1);
        check({tag, "_w2"}, int'(w2), e2);
        check({tag, "_b"}, int'(b), eb);
    endtask

    task automatic run_train(input int n, input bit stall, input int max_ep, input int abort_after,
                             output bit conv);
        int  mw1, mw2, mb, idx, ep, total, y, waits;
        bit  chg, fin;
        mw1 = 0; mw2 = 0; mb = 0; idx = 0; ep = 0; total = 0; chg = 0; fin = 0; conv = 0;
        @(negedge clk);
        start = 1'b1; nInput = n; dataReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("req_after_start", requestFlag, 1);
        check("done_after_start", done, 0);
        while (!fin) begin
            waits = !stall ? 0 : (total == 0 ? 5 : int'($urandom_range(0, 3)));
            for (int k = 0; k < waits; k++) begin
                dataReady = 1'b0;
                x1Input = 7'($urandom); x2Input = 7'($urandom); tInput = 2'($urandom);
                @(negedge clk);
                check("stall_req", requestFlag, 1);
                check_weights("stall", mw1, mw2, mb);
            end
            dataReady = 1'b1;
            x1Input = 7'(sx1[idx]); x2Input = 7'(sx2[idx]); tInput = 2'(st[idx]);
            @(negedge clk);
            check("update_req_low", requestFlag, 0);
            dataReady = !stall;
            x1Input = 7'($urandom); x2Input = 7'($urandom); tInput = 2'($urandom);
            y = act(mb + mw1 * sx1[idx] + mw2 * sx2[idx], 0);
            if (y != st[idx]) begin
                mw1 = clamp(mw1 + ALPHA * st[idx] * sx1[idx]);
                mw2 = clamp(mw2 + ALPHA * st[idx] * sx2[idx]);
                mb  = clamp(mb + ALPHA * st[idx]);
                chg = 1'b1;
            end
            @(negedge clk);
            check_weights("sample", mw1, mw2, mb);
            idx++; total++;
            if (idx == n) begin
                ep++;
                if (!chg) begin
                    fin = 1'b1; conv = 1'b1;
                end
                idx = 0; chg = 1'b0;
            end
            check("done_flag", done, int'(conv));
            check("req_flag", requestFlag, int'(!conv));
            if (!conv && (ep >= max_ep || total == abort_after)) fin = 1'b1;
        end
        dataReady = 1'b0;
        if (conv) begin
            repeat (3) begin
                start = 1'b1;
                @(negedge clk);
                check("held_done", done, 1);
                check("held_req", requestFlag, 0);
                check_weights("held", mw1, mw2, mb);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        bit conv;
        int sw1, sw2, sb;
        rst = 1'b1; start = 1'b0; dataReady = 1'b0; nInput = '0;
        x1Input = '0; x2Input = '0; tInput = '0;
        s_start = 1'b0; s_dr = 1'b0; s_n = '0; s_x1 = '0; s_x2 = '0; s_t = '0;
        repeat (2) @(negedge clk);
        check_weights("reset", 0, 0, 0);
        check("reset_done", done, 0);
        check("reset_req", requestFlag, 0);
        check("reset_sat_req", s_req, 0);
        rst = 1'b0;

        load_and();
        run_train(4, 1'b0, 10, -1, conv);
        check_weights("and_final", 1, 1, -1);

        do_reset();
        run_train(4, 1'b1, 10, -1, conv);
        check_weights("and_stall_final", 1, 1, -1);

        do_reset();
        run_train(4, 1'b0, 10, 3, conv);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_weights("midreset", 0, 0, 0);
        check("midreset_req", requestFlag, 0);
        check("midreset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req", requestFlag, 0);
        run_train(4, 1'b0, 10, -1, conv);
        check_weights("and_restart_final", 1, 1, -1);

        do_reset();
        @(negedge clk);
        start = 1'b1; nInput = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            check("zero_n_done", done, 1);
            check("zero_n_req", requestFlag, 0);
            @(negedge clk);
        end

        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) begin
                sx1[i] = int'($urandom_range(0, 127)) - 64;
                sx2[i] = int'($urandom_range(0, 127)) - 64;
                st[i]  = int'($urandom_range(0, 2)) - 1;
            end
            run_train(n, r[0], 8, -1, conv);
        end

        do_reset();
        @(negedge clk);
        s_start = 1'b1; s_n = 1; s_x1 = 63; s_x2 = -64; s_t = 1; s_dr = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("sat_req", s_req, 1);
        sw1 = 0; sw2 = 0; sb = 0;
        for (int k = 1; k <= 140; k++) begin
            repeat (2) @(negedge clk);
            if (act(sb + sw1 * 63 + sw2 * (-64), SAT_THETA) != 1) begin
                sw1 = clamp(sw1 + ALPHA * 63);
                sw2 = clamp(sw2 - ALPHA * 64);
                sb  = clamp(sb + ALPHA);
            end
            check("sat_w1", int'(s_w1), sw1);
            check("sat_w2", int'(s_w2), sw2);
            check("sat_b", int'(s_b), sb);
        end
        check("sat_w1_max", int'(s_w1), 8191);
        check("sat_w2_min", int'(s_w2), -8192);
        check("sat_not_done", s_done, 0);
        s_dr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
